// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM state type and GF(2^8) xtime helper
// Ports: none (package). Provides AES_KEY_W, AES_WORD_W, AES_MAX_ROUNDS,
//        RCON_INIT, RCON_POLY, state_t {IDLE, RUN} and xtime().
package aes_pkg;

  localparam int AES_KEY_W      = 128;
  localparam int AES_WORD_W     = 32;
  localparam int AES_MAX_ROUNDS = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic {IDLE, RUN} state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - combinational AES-128 single round-key expansion step
// Ports: prev_key[127:0] current round key, w0 at [127:96]
//        rcon[7:0]       round constant for the key being produced
//        next_key[127:0] following round key, same byte order
module aes_key_step
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0]  prev_key,
  input  logic [7:0]            rcon,
  output logic [AES_KEY_W-1:0]  next_key
);

  logic [AES_WORD_W-1:0] w0, w1, w2, w3;
  logic [AES_WORD_W-1:0] rot_w3, sub_w3;
  logic [AES_WORD_W-1:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;

  // RotWord: [b0 b1 b2 b3] -> [b1 b2 b3 b0]
  assign rot_w3 = {w3[23:0], w3[31:24]};

  sbox_32bit u_sbox (
    .in_word  (rot_w3),
    .out_word (sub_w3)
  );

  // Each word chains off the newly produced previous word.
  assign n0 = w0 ^ sub_w3 ^ {rcon, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/sbox_32bit.sv
// rtl/sbox_32bit.sv - four parallel AES forward S-box lookups on a 32-bit word
// Ports: in_word[31:0]  word to substitute, byte-wise
//        out_word[31:0] substituted word, same byte order
module sbox_32bit (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  // Row r holds S-box entries 16r..16r+15; entry 0 lands at the MSB.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_word = {SBOX[in_word[31:24]], SBOX[in_word[23:16]],
                     SBOX[in_word[15:8]],  SBOX[in_word[7:0]]};

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key schedule, one round key per advance
// Ports: clk, rst_n (async active-low)
//        start, cipher_key[127:0]  load a new key (IDLE only)
//        advance                   step to next round key (while key_valid)
//        key_valid, round_number[3:0], round_key[127:0]  current key
//        busy (RUN state), done (one-cycle pulse after last key consumed)
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int LAST_ROUND = AES_MAX_ROUNDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] cipher_key,
  input  logic                 advance,
  output logic                 key_valid,
  output logic [3:0]           round_number,
  output logic [AES_KEY_W-1:0] round_key,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] LAST_RN = 4'(LAST_ROUND);

  state_t                state;
  logic [7:0]            rcon;
  logic [AES_KEY_W-1:0]  next_key;

  aes_key_step u_step (
    .prev_key (round_key),
    .rcon     (rcon),
    .next_key (next_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      key_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      round_number <= 4'd0;
      round_key    <= '0;
      rcon         <= RCON_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            round_key    <= cipher_key;
            round_number <= 4'd0;
            rcon         <= RCON_INIT;
            key_valid    <= 1'b1;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            if (round_number == LAST_RN) begin
              // Last key consumed: key and index hold for inspection.
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              round_key    <= next_key;
              round_number <= round_number + 4'd1;
              rcon         <= xtime(rcon);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed self-checking bench for aes_key_schedule
module tb_aes_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] cipher_key;
  logic         advance;
  logic         key_valid;
  logic [3:0]   round_number;
  logic [127:0] round_key;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] fips_key;
  logic [127:0] zero_r1;
  logic [127:0] zero_r10;

  aes_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cipher_key   (cipher_key),
    .advance      (advance),
    .key_valid    (key_valid),
    .round_number (round_number),
    .round_key    (round_key),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fips_key    = fips_rk[0];
    zero_r1     = 128'h62636363626363636263636362636363;
    zero_r10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst_n = 1'b0; start = 1'b0; advance = 1'b0; cipher_key = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_key_valid", 128'(key_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_round_number", 128'(round_number), 128'd0);
    chk("rst_round_key", round_key, 128'd0);
    rst_n = 1'b1;

    // FIPS key, advance every cycle; key changes after start must not matter
    start = 1'b1; cipher_key = fips_key;
    @(negedge clk);
    start = 1'b0; cipher_key = {4{32'hdeadbeef}};
    chk("fips_kv0", 128'(key_valid), 128'd1);
    chk("fips_busy0", 128'(busy), 128'd1);
    chk("fips_rn0", 128'(round_number), 128'd0);
    chk("fips_rk0", round_key, fips_rk[0]);
    advance = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      chk($sformatf("fips_rn%0d", r), 128'(round_number), 128'(r));
      chk($sformatf("fips_rk%0d", r), round_key, fips_rk[r]);
      chk($sformatf("fips_nodone%0d", r), 128'(done), 128'd0);
    end
    @(negedge clk);
    advance = 1'b0;
    chk("fips_done", 128'(done), 128'd1);
    chk("fips_kv_end", 128'(key_valid), 128'd0);
    chk("fips_busy_end", 128'(busy), 128'd0);
    chk("fips_rn_hold", 128'(round_number), 128'd10);
    chk("fips_rk_hold", round_key, fips_rk[10]);
    @(negedge clk);
    chk("fips_done_once", 128'(done), 128'd0);

    // All-zero key
    start = 1'b1; cipher_key = '0;
    @(negedge clk);
    start = 1'b0; advance = 1'b1;
    @(negedge clk);
    chk("zero_rk1", round_key, zero_r1);
    repeat (9) @(negedge clk);
    chk("zero_rn10", 128'(round_number), 128'd10);
    chk("zero_rk10", round_key, zero_r10);
    @(negedge clk);
    advance = 1'b0;
    chk("zero_done", 128'(done), 128'd1);
    @(negedge clk);

    // Random stalls between steps
    start = 1'b1; cipher_key = fips_key;
    @(negedge clk);
    start = 1'b0;
    chk("stall_rk0", round_key, fips_rk[0]);
    for (int r = 1; r <= 10; r++) begin
      int n;
      n = $urandom_range(0, 5);
      repeat (n) begin
        @(negedge clk);
        chk($sformatf("stall_hold_rn%0d", r - 1), 128'(round_number), 128'(r - 1));
        chk($sformatf("stall_hold_rk%0d", r - 1), round_key, fips_rk[r - 1]);
      end
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      chk($sformatf("stall_rn%0d", r), 128'(round_number), 128'(r));
      chk($sformatf("stall_rk%0d", r), round_key, fips_rk[r]);
    end
    repeat (3) @(negedge clk);
    chk("stall_no_early_done", 128'(done), 128'd0);
    chk("stall_still_busy", 128'(busy), 128'd1);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    chk("stall_done", 128'(done), 128'd1);
    @(negedge clk);

    // Start during RUN is ignored
    start = 1'b1; cipher_key = fips_key;
    @(negedge clk);
    start = 1'b0; advance = 1'b1;
    repeat (4) @(negedge clk);
    advance = 1'b0; start = 1'b1; cipher_key = '0;
    @(negedge clk);
    start = 1'b0;
    chk("ign_rn4", 128'(round_number), 128'd4);
    chk("ign_rk4", round_key, fips_rk[4]);
    chk("ign_busy", 128'(busy), 128'd1);
    advance = 1'b1;
    for (int r = 5; r <= 10; r++) begin
      @(negedge clk);
      chk($sformatf("ign_rk%0d", r), round_key, fips_rk[r]);
      chk($sformatf("ign_busy%0d", r), 128'(busy), 128'd1);
    end
    @(negedge clk);
    advance = 1'b0;
    chk("ign_done", 128'(done), 128'd1);
    @(negedge clk);

    // Asynchronous reset at round 6
    start = 1'b1; cipher_key = fips_key;
    @(negedge clk);
    start = 1'b0; advance = 1'b1;
    repeat (6) @(negedge clk);
    advance = 1'b0;
    chk("mid_rn6", 128'(round_number), 128'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_kv", 128'(key_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_rn", 128'(round_number), 128'd0);
    chk("mid_rst_rk", round_key, 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    @(negedge clk);
    chk("mid_rst_nodone", 128'(done), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle_nodone", 128'(done), 128'd0);
    start = 1'b1; cipher_key = fips_key;
    @(negedge clk);
    start = 1'b0;
    chk("restart_rn0", 128'(round_number), 128'd0);
    chk("restart_rk0", round_key, fips_rk[0]);
    advance = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      chk($sformatf("restart_rk%0d", r), round_key, fips_rk[r]);
    end
    @(negedge clk);
    chk("restart_done", 128'(done), 128'd1);

    // Back-to-back: start in the done cycle with the zero key
    advance = 1'b0; start = 1'b1; cipher_key = '0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_kv", 128'(key_valid), 128'd1);
    chk("b2b_rn0", 128'(round_number), 128'd0);
    chk("b2b_rk0", round_key, 128'd0);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    chk("b2b_rk1", round_key, zero_r1);
    chk("b2b_rn1", 128'(round_number), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion. Sits directly upstream of the round function and drives its round_number and round_key inputs.
- Captures a 128-bit cipher key on start, then presents round keys 0..10 one at a time. Each step to the next key is requested by the round controller via advance.
- One new round key per advance; no key storage beyond the current round key, so area stays small.

Parameters:
- LAST_ROUND, 10, index of final round key. Legal range 1..10; the Rcon sequence covers rounds 1..10 only.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to load cipher_key; honoured only in IDLE
- cipher_key  in  128  AES key; byte k0 at [127:120], word w0 = [127:96]
- advance  in  1  step to next round key; honoured only while key_valid=1
- key_valid  out  1  round_number/round_key are valid
- round_number  out  4  index of the key currently presented (0..LAST_ROUND)
- round_key  out  128  current round key, same byte order as cipher_key
- busy  out  1  high in RUN state
- done  out  1  one-cycle pulse after the last key is consumed

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; key_valid=0, busy=0, done=0, round_number=0, round_key=0, rcon register=8'h01.
  - Reset mid-operation abandons the schedule immediately, with no done pulse.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge t: round_key<=cipher_key, round_number<=0, rcon<=8'h01, key_valid<=1, busy<=1, state<=RUN.
  - Outputs are valid after edge t, so latency from start is 1 cycle.
- RUN, advance=0: all outputs hold (stall supported indefinitely).
- RUN, advance=1, round_number<LAST_ROUND, next-key computation:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - RotWord([b0 b1 b2 b3]) = [b1 b2 b3 b0]; SubWord applies the existing AES S-box per byte.
  - round_number increments by 1. rcon <= xtime(rcon): shift left 1, XOR 8'h1b if bit7 was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
- RUN, advance=1, round_number==LAST_ROUND:
  - key_valid<=0, busy<=0, done<=1 for exactly one cycle, state<=IDLE.
  - round_key and round_number hold their last values.
- start while in RUN: ignored, no restart.
- start and advance in the same IDLE cycle: start wins; advance ignored because key_valid=0.
- start in the cycle done is high (state already IDLE): accepted normally, so back-to-back schedules are allowed.
- cipher_key is sampled only at the start edge; later changes have no effect.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package aes_pkg:
  - AES_KEY_W=128, AES_WORD_W=32, AES_MAX_ROUNDS=10, RCON_INIT=8'h01, RCON_POLY=8'h1b
  - xtime function
  - state enum {IDLE, RUN}
- One combinational sub-module, aes_key_step:
  - inputs prev_key[127:0] and rcon[7:0]; output next_key[127:0].
  - instantiates the existing sbox_32bit on RotWord(w3).
- Top level holds the FSM, counter and rcon register, and instantiates aes_key_step once.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, then advance every cycle:
  - round 0 = the key itself
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses exactly once, one cycle after round 10 is consumed
- All-zero key:
  - round 1 = 62636363626363636263636362636363
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e
- Stalls: FIPS key, advance randomly deasserted for 0-5 cycles between steps:
  - identical key sequence to the no-stall run
  - round_key and round_number stable throughout every stall
- Ignored start: pulse start with a different key during round 4:
  - schedule continues unchanged with the original key
  - busy stays 1 until done
- Reset mid-run: assert rst_n=0 asynchronously at round 6:
  - all outputs 0 immediately, no done pulse
  - a subsequent start restarts from round 0 with correct keys
- Back-to-back: start in the cycle done is high with the zero key:
  - key_valid=1 and round_number=0 on the next cycle
  - round 1 = 62636363…
